// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers for the iterative round controller and datapath.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_BYTES = AES_BLK_W / 8;
  localparam int unsigned NR_128    = 10;
  localparam int unsigned NR_192    = 12;
  localparam int unsigned NR_256    = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Forward S-box, row-major, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when last_i), AddRoundKey.
module aes_round_dp
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_i,
  input  logic [AES_BLK_W-1:0] rk_i,
  input  logic                 last_i,
  output logic [AES_BLK_W-1:0] result_c
);

  logic [7:0] sb [AES_BYTES];
  logic [7:0] sr [AES_BYTES];
  logic [7:0] mc [AES_BYTES];

  // Byte i = row (i%4), column (i/4); byte 0 sits in the top bits.
  for (genvar i = 0; i < AES_BYTES; i++) begin : g_sub
    assign sb[i] = sbox(state_i[AES_BLK_W-1-8*i -: 8]);
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sr[r+4*c] = sb[r+4*((c+r)%4)];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c+0];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    assign mc[4*c+0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  for (genvar i = 0; i < AES_BYTES; i++) begin : g_ark
    assign result_c[AES_BLK_W-1-8*i -: 8] =
      (last_i ? sr[i] : mc[i]) ^ rk_i[AES_BLK_W-1-8*i -: 8];
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: owns state register and round counter, drives an external round datapath.
// Define AES_ROUND_CTRL_ABORT_EN to add the abort input that drops an in-flight block.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_128,
  parameter int unsigned RW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic [RW-1:0]        rk_idx,
  input  logic [AES_BLK_W-1:0] rk_data,
  output logic [AES_BLK_W-1:0] dp_state,
  output logic                 dp_last,
  input  logic [AES_BLK_W-1:0] dp_result,
  output logic                 busy
`ifdef AES_ROUND_CTRL_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  if ((NR != NR_128) && (NR != NR_192) && (NR != NR_256)) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end
  if (NR >= (1 << RW)) begin : g_bad_rw
    $error("aes_round_ctrl: RW too narrow to hold NR");
  end

  aes_state_e           fsm_q, fsm_d;
  logic [AES_BLK_W-1:0] blk_q, blk_d;
  logic [RW-1:0]        round_q, round_d;
  logic                 last_rnd_c;

  assign last_rnd_c = (round_q == RW'(NR));
  assign out_data   = blk_q;
  assign dp_state   = blk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      blk_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      round_q <= round_d;
    end
  end

  // Next state and handshake/datapath controls.
  always_comb begin
    fsm_d     = fsm_q;
    blk_d     = blk_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    dp_last   = 1'b0;
    rk_idx    = '0;

    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = in_data ^ rk_data;
          round_d = RW'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        rk_idx  = round_q;
        dp_last = last_rnd_c;
        blk_d   = dp_result;
        if (last_rnd_c) begin
          round_d = '0;
          fsm_d   = DONE;
        end else begin
          round_d = round_q + RW'(1);
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort wins over out_ready and suppresses any ciphertext this cycle.
    if (abort && (fsm_q != IDLE)) begin
      fsm_d     = IDLE;
      round_d   = '0;
      blk_d     = '0;
      out_valid = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with aes_round_dp and a bench-side key schedule and AES model.
module tb_aes_round_ctrl;
  localparam int NR = 10;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [127:0] dp_state;
  logic         dp_last;
  logic [127:0] dp_result;
  logic         busy;
  logic         abort = 1'b0;

  logic [127:0] rk_tbl [16];
  logic [127:0] cur_key = '0;
  logic [7:0]   sb_ref [256];

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;
  int n_ov     = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  assign rk_data = rk_tbl[rk_idx];

  aes_round_ctrl #(.NR(NR), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .dp_state(dp_state), .dp_last(dp_last), .dp_result(dp_result),
    .busy(busy)
`ifdef AES_ROUND_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  aes_round_dp u_dp (
    .state_i(dp_state), .rk_i(rk_data), .last_i(dp_last), .result_c(dp_result)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a, p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]], sb_ref[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Whole-block reference encryption on a byte array.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, res;
    rk = round_key(key, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_ref[s[i]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (r < NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      rk = round_key(key, r);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic set_key(input logic [127:0] k);
    cur_key = k;
    for (int r = 0; r < 16; r++) rk_tbl[r] = (r <= NR) ? round_key(k, r) : '0;
  endtask

  // Timeline model: phase 0 idle, 1..NR round k, NR+1 ciphertext pending.
  int           m_phase = 0;
  logic [127:0] m_exp   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_phase = 0;
    else if (m_phase == 0) begin
      if (in_valid) begin
        m_exp   = aes_enc(in_data, cur_key);
        m_phase = 1;
      end
    end
    else if (abort) m_phase = 0;
    else if (m_phase <= NR) m_phase++;
    else if (out_ready) m_phase = 0;
  end

  always @(negedge clk) begin : compare
    bit e_ov;
    if (out_valid) n_ov++;
    if (out_valid && out_ready) n_hs++;
    if (chk_en) begin
      e_ov = (m_phase == NR + 1) && !abort;
      chk("in_ready", 128'(in_ready), 128'(m_phase == 0));
      chk("busy", 128'(busy), 128'(m_phase != 0));
      chk("out_valid", 128'(out_valid), 128'(e_ov));
      chk("rk_idx", 128'(rk_idx), (m_phase >= 1 && m_phase <= NR) ? 128'(m_phase) : 128'(0));
      chk("dp_last", 128'(dp_last), 128'(m_phase == NR));
      if (e_ov) chk("out_data", out_data, m_exp);
    end
  end

  task automatic accept_block(input logic [127:0] pt, input bit hold, output time t_acc);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    t_acc = 0;
    in_valid = 1'b1;
    in_data  = pt;
    while (!got && n < 40) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      t_acc = $time;
      #1;
      n++;
    end
    if (!hold) in_valid = 1'b0;
    if (!got) chk("accept_timeout", 128'(got), 128'(1));
  endtask

  task automatic wait_out(output int n, output logic [127:0] d);
    n = 0;
    d = '0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    if (!out_valid) chk("out_valid_timeout", 128'(out_valid), 128'(1));
    d = out_data;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]   inv;
    time          t0, t1, t2;
    int           n, base;
    logic [127:0] d;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_ref[x] = affine(inv);
    end
    for (int r = 0; r < 16; r++) rk_tbl[r] = '0;

    chk("pin_sbox_00", 128'(sb_ref[0]), 128'h63);
    chk("pin_sbox_53", 128'(sb_ref[8'h53]), 128'hed);
    chk("pin_rk10", round_key(KEY_B, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("pin_c1", aes_enc(PT_C1, KEY_C1), CT_C1);
    chk("pin_b", aes_enc(PT_B, KEY_B), CT_B);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    rst_n = 1'b1;

    // FIPS-197 C.1 with latency and key-index sequencing.
    set_key(KEY_C1);
    out_ready = 1'b1;
    accept_block(PT_C1, 1'b0, t0);
    for (int k = 1; k <= NR + 1; k++) begin
      @(negedge clk);
      if (k <= NR) begin
        chk("seq_rk_idx", 128'(rk_idx), 128'(k));
        chk("seq_dp_last", 128'(dp_last), 128'(k == NR));
        chk("seq_no_valid", 128'(out_valid), 128'(0));
      end else begin
        chk("lat_out_valid", 128'(out_valid), 128'(1));
        chk("c1_out_data", out_data, CT_C1);
      end
    end
    @(posedge clk);
    #1;
    chk("c1_back_idle", 128'(in_ready), 128'(1));

    // Backpressure in DONE.
    set_key(KEY_B);
    out_ready = 1'b0;
    accept_block(PT_B, 1'b0, t0);
    wait_out(n, d);
    chk("bp_latency", 128'(n), 128'(11));
    chk("bp_data", d, CT_B);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_hold", 128'(out_valid), 128'(1));
      chk("bp_data_hold", out_data, d);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 128'(out_valid), 128'(1));
    @(posedge clk);
    #1;
    chk("bp_idle_ready", 128'(in_ready), 128'(1));
    chk("bp_idle_valid", 128'(out_valid), 128'(0));

    // Back-to-back blocks with both handshakes held high.
    set_key(KEY_C1);
    base = n_hs;
    accept_block(PT_C1, 1'b1, t0);
    accept_block(PT_B, 1'b1, t1);
    accept_block(128'hdeadbeef_01234567_89abcdef_f0e1d2c3, 1'b0, t2);
    chk("b2b_gap01", 128'((t1 - t0) / 10), 128'(12));
    chk("b2b_gap12", 128'((t2 - t1) / 10), 128'(12));
    repeat (14) @(posedge clk);
    #1;
    chk("b2b_count", 128'(n_hs - base), 128'(3));

    // Reset in the middle of round 5.
    accept_block(PT_C1, 1'b0, t0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_rk", 128'(rk_idx), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("rstm_in_ready", 128'(in_ready), 128'(1));
    chk("rstm_out_valid", 128'(out_valid), 128'(0));
    chk("rstm_busy", 128'(busy), 128'(0));
    chk("rstm_dp_last", 128'(dp_last), 128'(0));
    chk("rstm_rk_idx", 128'(rk_idx), 128'(0));
    chk("rstm_out_data", out_data, 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = n_ov;
    repeat (15) @(posedge clk);
    #1;
    chk("rstm_no_valid", 128'(n_ov - base), 128'(0));
    accept_block(PT_C1, 1'b0, t0);
    wait_out(n, d);
    chk("rstm_next_lat", 128'(n), 128'(11));
    chk("rstm_next_data", d, CT_C1);
    @(posedge clk);
    #1;

    set_key(KEY_B);
`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort at round 3 drops the block.
    accept_block(PT_B, 1'b0, t0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_rk", 128'(rk_idx), 128'(3));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_idle_ready", 128'(in_ready), 128'(1));
    chk("abort_idle_busy", 128'(busy), 128'(0));
    base = n_ov;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_valid", 128'(n_ov - base), 128'(0));
`endif
    accept_block(PT_B, 1'b0, t0);
    wait_out(n, d);
    chk("final_lat", 128'(n), 128'(11));
    chk("final_data", d, CT_B);
    repeat (2) @(posedge clk);
    #1;

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES encryption sequencer. It owns the 128-bit state register and round counter, accepts one plaintext block per valid/ready handshake, and drives an external single-round datapath (SubBytes→ShiftRows→MixColumns→AddRoundKey) once per cycle. It requests round keys from the key-expansion store by index, asserts mixcol bypass on the final round, and presents ciphertext on a valid/ready output.

Parameters:
NR, 10, number of rounds (10/12/14 for AES-128/192/256); legal values only, else elaboration error
RW, 4, round counter / key index width; must hold NR

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  plaintext offered
in_ready  out  1  controller can accept plaintext
in_data  in  128  plaintext block, byte 0 in [127:120]
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
out_data  out  128  ciphertext = state register
rk_idx  out  RW  round-key index requested
rk_data  in  128  round key for rk_idx, combinational same cycle
dp_state  out  128  state fed to round datapath
dp_last  out  1  final round: datapath bypasses MixColumns
dp_result  in  128  combinational round output for dp_state/dp_last/rk_data
busy  out  1  high in ROUND or DONE

Behaviour:
- States: IDLE, ROUND, DONE. Reset: IDLE, state reg=0, round=0; in_ready=1, out_valid=0, busy=0, dp_last=0, rk_idx=0.
- IDLE: in_ready=1, rk_idx=0. On in_valid: state<=in_data^rk_data, round<=1, →ROUND.
- ROUND: rk_idx=round, dp_state=state, dp_last=(round==NR). Each cycle state<=dp_result, round<=round+1. When round==NR: →DONE and round<=0. No stall inside ROUND.
- DONE: out_valid=1, out_data=state held stable until out_ready; on out_ready →IDLE. in_ready=0 in ROUND and DONE; no input is accepted in the handshake cycle.
- Latency: accept at cycle T; out_valid first high at T+NR+1. Minimum block period NR+2 cycles with out_ready tied high.
- dp_last=0 outside ROUND. rk_idx is never >NR and never wraps.
- in_valid with in_ready=0 is ignored; upstream must hold.
- rst_n asserted in any state returns to reset values immediately. An in-flight block is discarded and no partial out_valid is produced.
- out_data reflects the state register at all times. Only the value under out_valid is meaningful.

Optional Feature:
Macro AES_ROUND_CTRL_ABORT_EN.
- Defined: adds input abort (1b). abort=1 in ROUND or DONE → next state IDLE, round<=0, state<=0, no out_valid. This takes priority over out_ready. Ignored in IDLE. In-flight abort asserts for that cycle only.
- Undefined: no abort port. Only rst_n terminates a block.

Decomposition:
- Package aes_pkg: state enum {IDLE,ROUND,DONE}, constants NR_128=10, NR_192=12, NR_256=14, AES_BLK_W=128.
- One natural sub-module: aes_round_dp, the combinational round function with dp_last bypass, which the bench instantiates alongside the controller.
- Key expansion stays external, reached through rk_idx/rk_data.

Test Plan:
- FIPS-197 C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → out_data 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid at T+11.
- Sequencing check: rk_idx goes 0,1,…,10 on consecutive cycles from accept. dp_last is high only in the rk_idx=10 cycle.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid and out_data stable, in_ready=0. Release → IDLE next cycle, in_ready=1.
- Back-to-back: in_valid and out_ready held high for 3 blocks → accepts exactly 12 cycles apart, 3 correct ciphertexts, no drops.
- Reset mid-round: rst_n low at round 5 → same-cycle outputs at reset values. Next block after release is encrypted correctly.
- ABORT_EN build: abort at round 3 → IDLE next cycle, no out_valid, following block correct. Non-ABORT build: port absent, and the same stimulus minus abort gives the correct ciphertext.
